fifo_pkt_reader: RTL and testbench

//  Read-side consumer for the 64x8 sync FIFO: drains bytes into fixed-length packets on a valid/ready link.

---
 rtl/fifo_rd_pkg.sv | 9 +
 rtl/fifo_rd_skid.sv | 47 ++++
 rtl/fifo_pkt_reader.sv | 129 ++++++++++++
 tb/tb_fifo_pkt_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizes for the FIFO packet reader and its output skid.
package fifo_rd_pkg;
    typedef enum logic {IDLE, READ} state_t;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 64;
    localparam int SKID_DEPTH = 4;
    localparam int SKID_AW    = $clog2(SKID_DEPTH);
endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular buffer absorbing FIFO read latency; push/pop may coincide.
module fifo_rd_skid
    import fifo_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [SKID_AW:0]  occ
);
    logic [DATA_W-1:0]  mem_q [SKID_DEPTH];
    logic [SKID_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SKID_AW:0]   occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + SKID_AW'(push);
        rd_ptr_d = rd_ptr_q + SKID_AW'(pop);
        occ_d    = occ_q + (SKID_AW+1)'(push) - (SKID_AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entries are cleared so the link data reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;
endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains the sync FIFO into fixed-length packets on a valid/ready link.
// Optional FIFO_RD_HDR_EN prepends a length header byte to every packet.
module fifo_pkt_reader
    import fifo_rd_pkg::*;
#(
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 7,
    parameter int PCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [7:0]        fifo_data,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              flush,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              busy,
    output logic [PCNT_W-1:0] pkt_cnt
);
    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rd_left_q, rd_left_d;
    logic [CNT_W:0]      tx_left_q, tx_left_d;
    logic                first_q, first_d;
    logic                inflight_q;
    logic [PCNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [SKID_AW:0]    skid_occ;
    logic [DATA_W-1:0]   skid_head;
    logic [DATA_W-1:0]   push_data;
    logic                push;
    logic                start;
    logic                rd_en;
    logic                beat;
    logic [CNT_W-1:0]    len_start;
    logic [CNT_W:0]      tx_len_start;

    assign start     = (state_q == IDLE) &&
                       ((fifo_count >= PKT_LEN_C) || (flush && (fifo_count != '0)));
    assign len_start = (fifo_count >= PKT_LEN_C) ? PKT_LEN_C : fifo_count;

    // Issue only when the skid can still hold every byte already requested.
    assign rd_en = (state_q == READ) && (rd_left_q != '0) && !fifo_empty &&
                   (({1'b0, skid_occ} + {{SKID_AW{1'b0}}, inflight_q}) <= (SKID_AW+2)'(2));

    assign beat = tx_valid && tx_ready;

`ifdef FIFO_RD_HDR_EN
    assign push         = inflight_q || start;
    assign push_data    = inflight_q ? fifo_data : {1'b0, len_start[6:0]};
    assign tx_len_start = {1'b0, len_start} + (CNT_W+1)'(1);
`else
    assign push         = inflight_q;
    assign push_data    = fifo_data;
    assign tx_len_start = {1'b0, len_start};
`endif

    always_comb begin
        state_d   = state_q;
        rd_left_d = rd_left_q;
        tx_left_d = tx_left_q;
        first_d   = first_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    rd_left_d = len_start;
                    tx_left_d = tx_len_start;
                    first_d   = 1'b1;
                end
            end
            READ: begin
                if (rd_en) rd_left_d = rd_left_q - CNT_W'(1);
                if (beat) begin
                    first_d   = 1'b0;
                    tx_left_d = tx_left_q - (CNT_W+1)'(1);
                    if (tx_left_q == (CNT_W+1)'(1)) begin
                        state_d   = IDLE;
                        pkt_cnt_d = pkt_cnt_q + PCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_left_q  <= '0;
            tx_left_q  <= '0;
            first_q    <= 1'b0;
            inflight_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_left_q  <= rd_left_d;
            tx_left_q  <= tx_left_d;
            first_q    <= first_d;
            inflight_q <= rd_en;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    fifo_rd_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (beat),
        .head      (skid_head),
        .occ       (skid_occ)
    );

    assign fifo_rd_en = rd_en;
    assign tx_valid   = (skid_occ != '0);
    assign tx_data    = skid_head;
    assign tx_sof     = tx_valid && first_q;
    assign tx_eof     = tx_valid && (tx_left_q == (CNT_W+1)'(1));
    assign busy       = (state_q != IDLE);
    assign pkt_cnt    = pkt_cnt_q;
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader with a behavioural 64x8 FIFO on its read side.
module tb_fifo_pkt_reader;
`ifdef FIFO_RD_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic [6:0]  fifo_count;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic        busy;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int failures = 0;
    int exp_pkt_cnt = 0;

    always #5 clk = ~clk;

    fifo_pkt_reader dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .flush      (flush),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt)
    );

    // FIFO model: bulk load from the bench, registered 1-cycle read for the DUT.
    logic [7:0] fmem [64];
    logic [5:0] f_wr, f_rd;
    logic [6:0] f_cnt;
    logic       load_req = 1'b0;
    int         load_n = 0;
    logic [7:0] load_base = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wr      <= '0;
            f_rd      <= '0;
            f_cnt     <= '0;
            fifo_data <= '0;
        end else begin
            if (load_req) begin
                for (int i = 0; i < load_n; i++) fmem[6'(f_wr + 6'(i))] <= load_base + 8'(i);
                f_wr <= f_wr + 6'(load_n);
            end
            if (fifo_rd_en) begin
                fifo_data <= fmem[f_rd];
                f_rd      <= f_rd + 6'd1;
            end
            f_cnt <= f_cnt + (load_req ? 7'(load_n) : 7'd0) - (fifo_rd_en ? 7'd1 : 7'd0);
        end
    end

    assign fifo_count = f_cnt;
    assign fifo_empty = (f_cnt == 7'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic load(input int n, input logic [7:0] base);
        load_n    = n;
        load_base = base;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    // Cycle 0 is the current negedge (the start-decision cycle). stop_after=0 runs the whole packet.
    task automatic run_pkt(input int n, input logic [7:0] base, input bit toggle,
                           input bit do_flush, input int stop_after);
        int total, limit, idx, cyc, first_cyc;
        logic pv, pr, ps, pe;
        logic [7:0] pd, exp_d;
        total = n + HDR;
        limit = (stop_after > 0) ? stop_after : total;
        idx = 0; cyc = 0; first_cyc = -1;
        pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0; pd = 8'h00;
        while (idx < limit && cyc < 300) begin
            if (do_flush) flush = (cyc == 0);
            tx_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            chk("occ_plus_inflight_le3",
                32'((32'(dut.skid_occ) + 32'(dut.inflight_q)) <= 32'd3), 32'd1);
            if (pv && !pr) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(pd));
                chk("hold_sof", 32'(tx_sof), 32'(ps));
                chk("hold_eof", 32'(tx_eof), 32'(pe));
            end
            if (tx_valid && first_cyc < 0) first_cyc = cyc;
            if (tx_valid && tx_ready) begin
                exp_d = (HDR == 1 && idx == 0) ? 8'(n) : base + 8'(idx - HDR);
                chk("beat_data", 32'(tx_data), 32'(exp_d));
                chk("beat_sof", 32'(tx_sof), 32'(idx == 0));
                chk("beat_eof", 32'(tx_eof), 32'(idx == total - 1));
                $display("beat pkt_base=%02h idx=%0d data=%02h sof=%0b eof=%0b", base, idx, tx_data, tx_sof, tx_eof);
                idx++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; ps = tx_sof; pe = tx_eof;
            cyc++;
            @(negedge clk);
        end
        flush    = 1'b0;
        tx_ready = 1'b1;
        chk("beat_count", 32'(idx), 32'(limit));
        chk("first_valid_latency", 32'(first_cyc), (HDR == 1) ? 32'd1 : 32'd3);
        if (stop_after == 0) begin
            exp_pkt_cnt++;
            chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt_cnt));
            chk("busy_after_eof", 32'(busy), 32'd0);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_sof"}, 32'(tx_sof), 32'd0);
        chk({tag, "_tx_eof"}, 32'(tx_eof), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full packet, link always ready.
        load(16, 8'h00);
        run_pkt(16, 8'h00, 1'b0, 1'b0, 0);

        // Same data with ready toggling.
        load(16, 8'h00);
        run_pkt(16, 8'h00, 1'b1, 1'b0, 0);

        // Short packet via flush.
        load(5, 8'h20);
        chk("no_start_below_len", 32'(busy), 32'd0);
        run_pkt(5, 8'h20, 1'b0, 1'b1, 0);

        // Flush with an empty FIFO does nothing.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        chk("empty_flush_busy", 32'(busy), 32'd0);
        chk("empty_flush_valid", 32'(tx_valid), 32'd0);
        chk("empty_flush_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt_cnt));

        // Full FIFO drains as four back-to-back packets.
        load(64, 8'h80);
        chk("full_count", 32'(fifo_count), 32'd64);
        for (int p = 0; p < 4; p++) run_pkt(16, 8'h80 + 8'(16 * p), 1'b0, 1'b0, 0);
        chk("full_drained_empty", 32'(fifo_empty), 32'd1);

        // Reset mid-packet aborts without eof, then a clean packet follows.
        load(16, 8'h40);
        run_pkt(16, 8'h40, 1'b0, 1'b0, 7);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("mid_reset");
        exp_pkt_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(16, 8'h50);
        run_pkt(16, 8'h50, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
